z80_irq_ctrl: RTL and testbench
===============================

Name: z80_irq_ctrl

Overview:
Parametrised interrupt controller that sits between the game's interrupt sources (vblank, sound latch, timers) and a Z80-class CPU core.
- Detects rising edges per source and keeps a per-source pending latch and an enable mask.
- Drives int_n and answers the interrupt-acknowledge cycle with a mode-2 vector for the highest-priority pending source.
- Exposes mask and pending registers on the CPU IO bus.
- Replaces the single hard-wired vblank latch used by earlier CPU wrappers.

Parameters:
NUM_SRC, 4, number of interrupt sources, legal range 1..8; index 0 has highest priority.
VEC_BASE, 8'hE0, mode-2 vector for source 0; source i returns VEC_BASE + 2*i, modulo 256.
IO_BASE, 8'h00, low IO address of the register block; occupies IO_BASE..IO_BASE+2.
MASK_RST, 8'hFF, reset value of the mask register; only the low NUM_SRC bits are used.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
src  in  NUM_SRC  interrupt request inputs, synchronous to clk_sys, active-high.
cpu_io  in  1  CPU IORQ, active-high.
cpu_m1  in  1  CPU M1, active-high.
cpu_rd  in  1  CPU RD, active-high.
cpu_wr  in  1  CPU WR, active-high.
cpu_ab  in  8  CPU address bus, low byte.
cpu_dout  in  8  data written by the CPU.
irq_dout  out  8  data to the CPU: vector during acknowledge, register value during IO read.
irq_dout_en  out  1  high when irq_dout must be muxed onto the CPU data-in bus.
int_n  out  1  interrupt request to the CPU, active-low.

Behaviour:
Reset values:
- src_d = 0, pending = 0, mask = MASK_RST[NUM_SRC-1:0], FSM = IDLE.
- int_n = 1, irq_dout = 8'h00, irq_dout_en = 0.

Edge detection:
- rise[i] = src[i] & ~src_d[i], with src_d registered every clk_sys.
- pending[i] is set on rise[i] whether or not mask[i] is set. Masking gates only int_n.

Interrupt output:
- int_n is registered: int_n <= ~|(pending & mask).
- One clk_sys of latency from a pending/mask change to int_n.

Acknowledge FSM:
- IDLE -> ACK on ack = cpu_io & cpu_m1.
  - Encode sel = lowest index with pending & mask set.
  - irq_dout <= VEC_BASE + 2*sel.
  - Clear pending[sel] in the same cycle.
- If no masked-pending bit exists (spurious acknowledge): irq_dout <= VEC_BASE + 2*NUM_SRC, and no pending bit changes.
- ACK holds irq_dout and asserts irq_dout_en while ack stays high.
- ACK -> IDLE when ack falls. A new acknowledge needs ack low for at least one clk_sys.

IO registers (decoded only when cpu_io & ~cpu_m1):
- IO_BASE
  - read: mask, zero-extended to 8 bits.
  - write: mask <= cpu_dout[NUM_SRC-1:0].
- IO_BASE+1
  - read: pending.
  - write: write-1-to-clear pending.
- IO_BASE+2
  - read: {5'b0, sel_valid, sel[1:0]} when NUM_SRC<=4; otherwise {4'b0, sel_valid, sel[2:0]}.
  - write: ignored.
- Reads: irq_dout_en = 1 and irq_dout = register value, combinationally while cpu_rd is high.
- Writes: take effect once, on the first clk_sys where cpu_wr is high (rising-edge detect on cpu_wr & decode).

Simultaneous events:
- rise[i] in the same cycle as a W1C clear or an ack-clear of bit i: set wins, pending[i] stays 1.
- Mask write in the same cycle as ack: the ack uses the old mask.
- Reset mid-acknowledge: FSM returns to IDLE, irq_dout_en drops immediately (asynchronous).

Optional Feature:
Macro IRQ_LEVEL_EN.
- Defined:
  - Adds a level register at IO_BASE+3 (read/write, reset 0).
  - When level[i] = 1, pending[i] tracks src[i] directly each cycle, and W1C and ack-clear have no lasting effect while src[i] is high.
  - Address IO_BASE+3 is decoded.
- Undefined:
  - All sources are edge-triggered.
  - IO_BASE+3 is not decoded: a read gives irq_dout_en = 0, a write is ignored.

Decomposition:
- Shared package z80_irq_pkg holds:
  - localparams for register offsets: REG_MASK = 0, REG_PEND = 1, REG_STAT = 2, REG_LEVEL = 3.
  - FSM state typedef {IDLE, ACK}.
  - MAX_SRC = 8.
- One natural sub-module, prio_enc: parametrised lowest-index-first priority encoder with outputs sel and sel_valid. It is reused by the vector path and the status register.

Test Plan:
1. Reset, then pulse src[2] for one cycle (mask FF) -> int_n = 0 two cycles later. Ack gives irq_dout = 8'hE4 and irq_dout_en = 1; pending reads 8'h00 afterwards; int_n returns to 1.
2. src[1] and src[3] rise together -> first ack returns 8'hE2, int_n stays 0; second ack returns 8'hE6, then int_n = 1.
3. Write mask = 8'h01, pulse src[2] -> int_n stays 1 and pending reads 8'h04. Write mask = 8'h05 -> int_n = 0 one cycle later.
4. Ack with pending = 0 -> irq_dout = 8'hE8 (spurious vector), pending unchanged.
5. W1C write of 8'h08 to IO_BASE+1 in the same cycle as rise[3] -> pending[3] remains 1.
6. With IRQ_LEVEL_EN: level = 8'h01, hold src[0] high, then ack -> pending[0] reads 1 again the next cycle. Drop src[0] -> pending[0] = 0.

Source files
------------

// File: rtl/z80_irq_pkg.sv
// Shared definitions for the Z80 interrupt controller: register offsets, FSM state, vector helper.
package z80_irq_pkg;

  localparam int MAX_SRC = 8;
  localparam int SEL_W   = $clog2(MAX_SRC);

  localparam logic [7:0] REG_MASK  = 8'd0;
  localparam logic [7:0] REG_PEND  = 8'd1;
  localparam logic [7:0] REG_STAT  = 8'd2;
  localparam logic [7:0] REG_LEVEL = 8'd3;

  typedef enum logic {IDLE, ACK} irq_state_t;

  // Mode-2 vectors are spaced two bytes apart and wrap modulo 256.
  function automatic logic [7:0] vec_of(input logic [7:0] base, input int idx);
    return base + 8'(2 * idx);
  endfunction

endpackage

// File: rtl/z80_irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational, no backpressure.
module prio_enc
  import z80_irq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid
);

  // Scan downward so the lowest set index is the last one assigned.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel       = SEL_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/z80_irq_ctrl.sv
// Edge-detecting interrupt controller with mode-2 vector acknowledge and IO-mapped mask/pending/status.
// int_n lags pending/mask by one clk_sys; optional level-sensitive sources under IRQ_LEVEL_EN.
module z80_irq_ctrl
  import z80_irq_pkg::*;
#(
  parameter int         NUM_SRC  = 4,
  parameter logic [7:0] VEC_BASE = 8'hE0,
  parameter logic [7:0] IO_BASE  = 8'h00,
  parameter logic [7:0] MASK_RST = 8'hFF
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic               cpu_io,
  input  logic               cpu_m1,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic [7:0]         cpu_ab,
  input  logic [7:0]         cpu_dout,
  output logic [7:0]         irq_dout,
  output logic               irq_dout_en,
  output logic               int_n
);

  localparam logic [7:0] A_MASK = IO_BASE + REG_MASK;
  localparam logic [7:0] A_PEND = IO_BASE + REG_PEND;
  localparam logic [7:0] A_STAT = IO_BASE + REG_STAT;

  logic [NUM_SRC-1:0] src_d, pending, mask, pend_nxt, act, rise, clr, wdat;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  irq_state_t         state, state_nxt;
  logic               ack_cyc, ack_start, ack_en;
  logic               io_cyc, wr_act, wr_q, wr_stb, rd_en;
  logic               hit_mask, hit_pend, hit_stat, hit_lvl;
  logic [7:0]         vec_q, rd_val, stat_val;
  logic               unused_dout;

  assign ack_cyc  = cpu_io & cpu_m1;
  assign io_cyc   = cpu_io & ~cpu_m1;
  assign wr_act   = io_cyc & cpu_wr;
  assign wr_stb   = wr_act & ~wr_q;
  assign rise     = src & ~src_d;
  assign act      = pending & mask;
  assign wdat     = cpu_dout[NUM_SRC-1:0];
  assign hit_mask = (cpu_ab == A_MASK);
  assign hit_pend = (cpu_ab == A_PEND);
  assign hit_stat = (cpu_ab == A_STAT);
  assign unused_dout = ^cpu_dout;

  prio_enc #(.N(NUM_SRC)) u_prio (
    .req       (act),
    .sel       (sel),
    .sel_valid (sel_valid)
  );

  assign stat_val = (NUM_SRC <= 4) ? {5'b0, sel_valid, sel[1:0]} : {4'b0, sel_valid, sel};

`ifdef IRQ_LEVEL_EN
  logic [NUM_SRC-1:0] level;
  assign hit_lvl = (cpu_ab == 8'(IO_BASE + REG_LEVEL));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                level <= '0;
    else if (wr_stb && hit_lvl)  level <= wdat;
  end
`else
  assign hit_lvl = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ack_cyc ? ACK : IDLE;
      ACK:     state_nxt = ack_cyc ? ACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_start = (state == IDLE) && ack_cyc;
    ack_en    = (state == ACK) && ack_cyc;
  end

  // A rise in the same cycle as any clear wins, so it is OR-ed in last.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_start && sel_valid && sel == SEL_W'(i)) clr[i] = 1'b1;
    end
    if (wr_stb && hit_pend) clr = clr | wdat;
    pend_nxt = (pending & ~clr) | rise;
`ifdef IRQ_LEVEL_EN
    pend_nxt = (pend_nxt & ~level) | (src & level);
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      src_d   <= '0;
      pending <= '0;
      mask    <= MASK_RST[NUM_SRC-1:0];
      int_n   <= 1'b1;
      vec_q   <= 8'h00;
      wr_q    <= 1'b0;
    end else begin
      src_d   <= src;
      pending <= pend_nxt;
      int_n   <= ~|act;
      wr_q    <= wr_act;
      if (wr_stb && hit_mask) mask <= wdat;
      if (ack_start) vec_q <= sel_valid ? vec_of(VEC_BASE, int'(sel)) : vec_of(VEC_BASE, NUM_SRC);
    end
  end

  always_comb begin
    rd_val = 8'h00;
    if (hit_mask)      rd_val[NUM_SRC-1:0] = mask;
    else if (hit_pend) rd_val[NUM_SRC-1:0] = pending;
    else if (hit_stat) rd_val = stat_val;
`ifdef IRQ_LEVEL_EN
    else if (hit_lvl)  rd_val[NUM_SRC-1:0] = level;
`endif
  end

  assign rd_en       = io_cyc & cpu_rd & (hit_mask | hit_pend | hit_stat | hit_lvl);
  assign irq_dout    = rd_en ? rd_val : vec_q;
  assign irq_dout_en = ack_en | rd_en;

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Directed plus randomized bench for z80_irq_ctrl against a per-cycle behavioural model.
module tb_z80_irq_ctrl;

  localparam int NSRC     = 4;
  localparam int FULL     = (1 << NSRC) - 1;
  localparam int VEC_BASE = 'hE0;
  localparam logic [7:0] IO_BASE = 8'h00;
`ifdef IRQ_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  logic            clk_sys = 1'b0;
  logic            reset_n;
  logic [NSRC-1:0] src;
  logic            cpu_io, cpu_m1, cpu_rd, cpu_wr;
  logic [7:0]      cpu_ab, cpu_dout;
  logic [7:0]      irq_dout;
  logic            irq_dout_en;
  logic            int_n;

  z80_irq_ctrl #(
    .NUM_SRC  (NSRC),
    .VEC_BASE (8'hE0),
    .IO_BASE  (IO_BASE),
    .MASK_RST (8'hFF)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .src         (src),
    .cpu_io      (cpu_io),
    .cpu_m1      (cpu_m1),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_ab      (cpu_ab),
    .cpu_dout    (cpu_dout),
    .irq_dout    (irq_dout),
    .irq_dout_en (irq_dout_en),
    .int_n       (int_n)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers updated once per clock from the rules.
  int pend_m, mask_m, lvl_m, src_prev, vec_m;
  bit intn_m;
  bit ev_ack, ev_w1c, ev_mask, ev_lvl;
  int ev_data;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lowest();
    for (int i = 0; i < NSRC; i++)
      if ((((pend_m & mask_m) >> i) & 1) != 0) return i;
    return -1;
  endfunction

  function automatic logic [7:0] stat_m();
    int k = lowest();
    return (k < 0) ? 8'h00 : 8'(4 + k);
  endfunction

  task automatic model_reset();
    pend_m = 0; mask_m = FULL; lvl_m = 0; src_prev = 0; vec_m = 0; intn_m = 1'b1;
    ev_ack = 0; ev_w1c = 0; ev_mask = 0; ev_lvl = 0; ev_data = 0;
  endtask

  task automatic tick();
    int s, rises, clrs, k;
    s      = int'(src);
    rises  = s & ~src_prev & FULL;
    intn_m = ((pend_m & mask_m) == 0);
    clrs   = 0;
    if (ev_ack) begin
      k = lowest();
      if (k >= 0) begin
        clrs  = 1 << k;
        vec_m = (VEC_BASE + 2 * k) % 256;
      end else begin
        vec_m = (VEC_BASE + 2 * NSRC) % 256;
      end
    end
    if (ev_w1c) clrs = clrs | ev_data;
    pend_m = ((pend_m & ~clrs) | rises) & FULL;
    pend_m = (pend_m & ~lvl_m) | (s & lvl_m);
    if (ev_mask) mask_m = ev_data & FULL;
    if (ev_lvl)  lvl_m  = ev_data & FULL;
    src_prev = s;
    ev_ack = 0; ev_w1c = 0; ev_mask = 0; ev_lvl = 0;
    @(posedge clk_sys);
    #1;
  endtask

  // Write held for two clocks: the register must update only once.
  task automatic io_write(input logic [7:0] off, input logic [7:0] data);
    cpu_ab = IO_BASE + off; cpu_dout = data; cpu_io = 1'b1; cpu_wr = 1'b1;
    ev_data = int'(data);
    ev_mask = (off == 8'd0);
    ev_w1c  = (off == 8'd1);
    ev_lvl  = (off == 8'd3) && LVL;
    tick();
    tick();
    cpu_io = 1'b0; cpu_wr = 1'b0;
    tick();
  endtask

  task automatic io_read(input logic [7:0] off, input logic [7:0] exp, input string tag);
    cpu_ab = IO_BASE + off; cpu_io = 1'b1; cpu_rd = 1'b1;
    #1;
    check({tag, "_en"}, {7'b0, irq_dout_en}, 8'h01);
    check(tag, irq_dout, exp);
    cpu_io = 1'b0; cpu_rd = 1'b0;
    #1;
  endtask

  task automatic do_ack(input string tag);
    cpu_io = 1'b1; cpu_m1 = 1'b1; ev_ack = 1'b1;
    tick();
    check({tag, "_en"}, {7'b0, irq_dout_en}, 8'h01);
    check({tag, "_vec"}, irq_dout, 8'(vec_m));
    tick();
    check({tag, "_hold"}, irq_dout, 8'(vec_m));
    cpu_io = 1'b0; cpu_m1 = 1'b0;
    #1;
    check({tag, "_off"}, {7'b0, irq_dout_en}, 8'h00);
    tick();
  endtask

  task automatic pulse(input logic [NSRC-1:0] v);
    src = v;
    tick();
    src = '0;
    tick();
  endtask

  initial begin
    int op;
    reset_n = 1'b0; src = '0;
    cpu_io = 0; cpu_m1 = 0; cpu_rd = 0; cpu_wr = 0; cpu_ab = 0; cpu_dout = 0;
    model_reset();
    #12;
    check("rst_int_n", {7'b0, int_n}, 8'h01);
    check("rst_dout", irq_dout, 8'h00);
    check("rst_en", {7'b0, irq_dout_en}, 8'h00);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // 1: single source, two-cycle int_n latency, vector E4
    src = 4'b0100;
    tick();
    check("t1_int_early", {7'b0, int_n}, 8'h01);
    src = '0;
    tick();
    check("t1_int_n", {7'b0, int_n}, 8'h00);
    do_ack("t1_ack");
    check("t1_vec_const", irq_dout, 8'hE4);
    io_read(8'd1, 8'h00, "t1_pend");
    check("t1_int_clr", {7'b0, int_n}, 8'h01);

    // 2: two sources together, priority order
    pulse(4'b1010);
    do_ack("t2_ack1");
    check("t2_vec1", irq_dout, 8'hE2);
    check("t2_int_still", {7'b0, int_n}, 8'h00);
    do_ack("t2_ack2");
    check("t2_vec2", irq_dout, 8'hE6);
    check("t2_int_done", {7'b0, int_n}, 8'h01);

    // 3: masking gates int_n but not pending
    io_write(8'd0, 8'h01);
    pulse(4'b0100);
    tick();
    check("t3_int_masked", {7'b0, int_n}, 8'h01);
    io_read(8'd1, 8'h04, "t3_pend");
    io_read(8'd0, 8'h01, "t3_mask");
    io_write(8'd0, 8'h05);
    check("t3_int_unmask", {7'b0, int_n}, 8'h00);
    do_ack("t3_ack");

    // 4: spurious acknowledge
    io_write(8'd0, 8'hFF);
    io_read(8'd2, 8'h00, "t4_stat");
    do_ack("t4_spur");
    check("t4_vec", irq_dout, 8'hE8);
    io_read(8'd1, 8'h00, "t4_pend");

    // 5: W1C collides with a rise of the same bit
    src = 4'b1000;
    io_write(8'd1, 8'h08);
    src = '0;
    tick();
    io_read(8'd1, 8'h08, "t5_pend");
    io_read(8'd2, 8'h07, "t5_stat");
    do_ack("t5_ack");

`ifdef IRQ_LEVEL_EN
    // 6: level-sensitive source survives acknowledge while held
    io_write(8'd3, 8'h01);
    io_read(8'd3, 8'h01, "t6_lvl");
    src = 4'b0001;
    tick();
    do_ack("t6_ack");
    io_read(8'd1, 8'h01, "t6_pend_held");
    src = '0;
    tick();
    io_read(8'd1, 8'h00, "t6_pend_drop");
    io_write(8'd3, 8'h00);
`else
    cpu_ab = IO_BASE + 8'd3; cpu_io = 1'b1; cpu_rd = 1'b1;
    #1;
    check("t6_nodec_en", {7'b0, irq_dout_en}, 8'h00);
    cpu_io = 1'b0; cpu_rd = 1'b0;
    tick();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      src = NSRC'($urandom);
      op  = $urandom_range(0, 6);
      case (op)
        0: do_ack("r_ack");
        1: io_write(8'd0, 8'($urandom));
        2: io_write(8'd1, 8'($urandom));
        3: io_read(8'd1, 8'(pend_m), "r_pend");
        4: io_read(8'd0, 8'(mask_m), "r_mask");
        5: io_read(8'd2, stat_m(), "r_stat");
        default: tick();
      endcase
      check("r_int_n", {7'b0, int_n}, {7'b0, intn_m});
    end

    // Reset in the middle of an acknowledge
    src = '0;
    io_write(8'd0, 8'hFF);
    pulse(4'b0010);
    cpu_io = 1'b1; cpu_m1 = 1'b1; ev_ack = 1'b1;
    tick();
    check("rst_ack_en", {7'b0, irq_dout_en}, 8'h01);
    reset_n = 1'b0;
    #1;
    check("rst_mid_en", {7'b0, irq_dout_en}, 8'h00);
    check("rst_mid_int", {7'b0, int_n}, 8'h01);
    check("rst_mid_dout", irq_dout, 8'h00);
    cpu_io = 1'b0; cpu_m1 = 1'b0;
    model_reset();
    #2;
    reset_n = 1'b1;
    tick();
    io_read(8'd0, 8'h0F, "rst_mask");
    io_read(8'd1, 8'h00, "rst_pend");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
